// File: rtl/pfa_out_addr_gen.sv
// Prime-factor output address generator.
// Walks the index triple (k1,k2,k3) with k3 fastest and k1 slowest, and emits
// addr = (k1*A1 + k2*A2 + k3*A3) mod N, with N = N1*N2*N3. The address is
// built from running modular sums, so the address path uses adders only.
// Optional build macro: PFA_OUT_ADDR_CHK_EN adds a LOAD-time range check of
// the factor sizes and weights, reported on err.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | latch sizes and weights, compute N, clear indices and sums
// RUN   | presenting one address per cycle, advancing on valid && ready
// DONE  | final beat accepted, one-cycle done pulse
module pfa_out_addr_gen #(
  parameter int wDataInOut = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  input  logic [wDataInOut-1:0] Nf1,
  input  logic [wDataInOut-1:0] Nf2,
  input  logic [wDataInOut-1:0] Nf3,
  input  logic [wDataInOut-1:0] A1,
  input  logic [wDataInOut-1:0] A2,
  input  logic [wDataInOut-1:0] A3,
  input  logic                  ready,
  output logic [wDataInOut-1:0] k1,
  output logic [wDataInOut-1:0] k2,
  output logic [wDataInOut-1:0] k3,
  output logic [wDataInOut-1:0] addr,
  output logic                  valid,
  output logic                  last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W = wDataInOut;
  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [W-1:0] n1_q, n2_q, n3_q, n_q;
  logic [W-1:0] a1_q, a2_q, a3_q;
  logic [W-1:0] s1_q, s12_q;
  logic [W-1:0] n_in;
  logic [W-1:0] addr_a3, s12_next, s1_next;
  logic         k1_wrap, k2_wrap, k3_wrap, last_beat;
  logic         param_bad;

  // Single conditional subtract is enough because both operands are < m.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] m);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, m})
      sum = sum - {1'b0, m};
    return sum[W-1:0];
  endfunction

  assign n_in      = Nf1 * Nf2 * Nf3;
  assign k1_wrap   = (k1 == n1_q - ONE);
  assign k2_wrap   = (k2 == n2_q - ONE);
  assign k3_wrap   = (k3 == n3_q - ONE);
  assign last_beat = k1_wrap && k2_wrap && k3_wrap;
  assign addr_a3   = mod_add(addr, a3_q, n_q);
  assign s12_next  = mod_add(s12_q, a2_q, n_q);
  assign s1_next   = mod_add(s1_q, a1_q, n_q);

`ifdef PFA_OUT_ADDR_CHK_EN
  localparam logic [W-1:0] TWO = W'(2);

  logic err_q;

  assign param_bad = (Nf1 < TWO) || (Nf2 < TWO) || (Nf3 < TWO) ||
                     (A1 >= n_in) || (A2 >= n_in) || (A3 >= n_in);
  assign err = err_q;

  // Sticky parameter error: set by a failed LOAD, cleared by an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_q <= 1'b0;
    else if (clr)
      err_q <= 1'b0;
    else if (state_q == IDLE && start)
      err_q <= 1'b0;
    else if (state_q == LOAD && param_bad)
      err_q <= 1'b1;
  end
`else
  assign param_bad = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and handshake flags; clr wins over everything.
  always_comb begin
    state_d = state_q;
    valid   = 1'b0;
    last    = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start)
          state_d = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        state_d = param_bad ? IDLE : RUN;
      end
      RUN: begin
        busy  = 1'b1;
        valid = 1'b1;
        last  = last_beat;
        if (ready && last_beat)
          state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr)
      state_d = IDLE;
  end

  // Parameter latch and incremental index/address walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n1_q  <= '0;
      n2_q  <= '0;
      n3_q  <= '0;
      n_q   <= '0;
      a1_q  <= '0;
      a2_q  <= '0;
      a3_q  <= '0;
      s1_q  <= '0;
      s12_q <= '0;
      k1    <= '0;
      k2    <= '0;
      k3    <= '0;
      addr  <= '0;
    end else if (clr) begin
      s1_q  <= '0;
      s12_q <= '0;
      k1    <= '0;
      k2    <= '0;
      k3    <= '0;
      addr  <= '0;
    end else if (state_q == LOAD) begin
      n1_q  <= Nf1;
      n2_q  <= Nf2;
      n3_q  <= Nf3;
      n_q   <= n_in;
      a1_q  <= A1;
      a2_q  <= A2;
      a3_q  <= A3;
      s1_q  <= '0;
      s12_q <= '0;
      k1    <= '0;
      k2    <= '0;
      k3    <= '0;
      addr  <= '0;
    end else if (state_q == RUN && ready && !last_beat) begin
      if (!k3_wrap) begin
        k3   <= k3 + ONE;
        addr <= addr_a3;
      end else begin
        k3 <= '0;
        if (!k2_wrap) begin
          k2    <= k2 + ONE;
          s12_q <= s12_next;
          addr  <= s12_next;
        end else begin
          k2    <= '0;
          k1    <= k1 + ONE;
          s1_q  <= s1_next;
          s12_q <= s1_next;
          addr  <= s1_next;
        end
      end
    end
  end

endmodule
